// File: rtl/modport_fifo_pkg.sv
// Shared defaults and sizing helpers for the modport_fifo slice.
// Optional error flags are enabled with the MODPORT_FIFO_ERR_EN macro.
package modport_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  // Number of address bits needed to index depth entries (clog2).
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/modport_fifo_if.sv
// FIFO access bundle; master = producer/consumer side, slave = FIFO side.
// overflow/underflow exist only when MODPORT_FIFO_ERR_EN is defined.
interface modport_fifo_if
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  // Handshake: a write is taken on a rising edge when wr_en && !full, a read
  // when rd_en && !empty; full/empty reflect the count after the last edge and
  // the read value appears on data_out one edge after the accepted read.
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
`ifdef MODPORT_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output wr_en,
    output rd_en,
    output data_in,
`ifdef MODPORT_FIFO_ERR_EN
    input  overflow,
    input  underflow,
`endif
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  data_in,
`ifdef MODPORT_FIFO_ERR_EN
    output overflow,
    output underflow,
`endif
    output data_out,
    output full,
    output empty
  );

endinterface

// File: rtl/modport_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write and one registered
// read port; only the read register is reset, the array keeps stale contents.
module modport_fifo_mem
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int PTR_W      = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // rst_n is active-high; the read register holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/modport_fifo.sv
// Synchronous FIFO top: pointers, occupancy count and flags around the
// storage sub-module. MODPORT_FIFO_ERR_EN adds registered overflow/underflow.
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  modport_fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_acc;
  logic             rd_acc;

  assign bus.full  = (count == CNT_W'(DEPTH));
  assign bus.empty = (count == '0);

  // Full blocks the write and empty blocks the read, so both accepted at
  // once never hit the same slot and no bypass path is needed.
  assign wr_acc = bus.wr_en && !bus.full;
  assign rd_acc = bus.rd_en && !bus.empty;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  modport_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

`ifdef MODPORT_FIFO_ERR_EN
  // A write on full paired with a read is a legal drain, not an overflow.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow  <= bus.wr_en && bus.full && !bus.rd_en;
      bus.underflow <= bus.rd_en && bus.empty;
    end
  end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Bench for modport_fifo: directed steps then random traffic against a queue
// model. Also checks overflow/underflow when MODPORT_FIFO_ERR_EN is defined.
module tb_modport_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  modport_fifo_if #(.DATA_WIDTH(DW)) bus ();

  modport_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference model: a plain queue of stored words plus the last read value.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_udf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_dout));
    check({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
    check({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
`ifdef MODPORT_FIFO_ERR_EN
    check({tag, ".overflow"},  32'(bus.overflow),  32'(exp_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_udf));
`endif
  endtask

  // One clock: drive at the falling edge, apply the model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] din,
                       input string tag);
    bit was_full;
    bit was_empty;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    @(posedge clk);
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    exp_ovf   = wr && was_full && !rd;
    exp_udf   = rd && was_empty;
    if (rd && !was_empty) exp_dout = exp_q.pop_front();
    if (wr && !was_full)  exp_q.push_back(din);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.data_in = 8'hA5;
    @(posedge clk);
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    int wr_pct;
    int rd_pct;
    logic [DW-1:0] d;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    exp_dout    = '0;
    exp_ovf     = 1'b0;
    exp_udf     = 1'b0;
    @(negedge clk);

    // Reset with requests asserted, then idle.
    do_reset("reset0");
    do_reset("reset1");
    cycle(1'b0, 1'b0, 8'h00, "idle");

    // Fill 0x11..0x18, one dropped write on full, then drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h11 + i), "fill8");
    cycle(1'b1, 1'b0, 8'hFF, "write_on_full");
    cycle(1'b0, 1'b0, 8'h00, "hold_after_drop");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, "drain8");

    // Reads while empty, then simultaneous wr/rd while empty.
    cycle(1'b0, 1'b1, 8'h00, "read_empty");
    cycle(1'b0, 1'b0, 8'h00, "after_read_empty");
    cycle(1'b1, 1'b1, 8'h3C, "wr_rd_empty");
    cycle(1'b0, 1'b1, 8'h00, "read_bypassed_word");

    // Four stored, then ten cycles of streaming with wraparound.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), "prefill4");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, DW'(8'h50 + i), "stream");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "stream_drain");

    // Full with wr_en and rd_en together: only the read is taken.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h60 + i), "refill");
    cycle(1'b1, 1'b1, 8'hEE, "wr_rd_full");
    cycle(1'b1, 1'b0, 8'h77, "refill_last");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, "drain_after_full");

    // Reset with five entries stored, then a read on the emptied FIFO.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h80 + i), "fill5");
    do_reset("reset_mid");
    cycle(1'b0, 1'b1, 8'h00, "read_after_reset");

    // Random traffic with shifting write/read bias and rare resets.
    for (int blk = 0; blk < 16; blk++) begin
      wr_pct = $urandom_range(10, 90);
      rd_pct = $urandom_range(10, 90);
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 99) == 0) begin
          do_reset("rand_reset");
        end else begin
          d = DW'($urandom);
          cycle(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
                d, "random");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data_in/data_out in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, >= 2.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-high despite the name suffix.
REQ-006 wr_en  input  1  write request.
REQ-007 rd_en  input  1  read request.
REQ-008 data_in  input  DATA_WIDTH  write data, sampled on a rising edge with an accepted write.
REQ-009 data_out  output  DATA_WIDTH  registered read data.
REQ-010 full  output  1  high when DEPTH entries are stored.
REQ-011 empty  output  1  high when 0 entries are stored.

Function
REQ-012 Synchronous FIFO, first-in first-out order; write and read pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-013 Occupancy count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 Write accepted iff wr_en && !full: store data_in at the write pointer and advance the write pointer.
REQ-015 Read accepted iff rd_en && !empty: load the entry at the read pointer into data_out on that edge (1-cycle latency) and advance the read pointer.
REQ-016 data_out holds its previous value on any cycle without an accepted read.
REQ-017 Write on full is dropped; storage, pointers and count are unchanged.
REQ-018 Read on empty is dropped; data_out and pointers are unchanged.
REQ-019 Simultaneous accepted read and write: both pointers advance and count is unchanged.
REQ-020 Simultaneous wr_en and rd_en while full: only the read is accepted and count decrements.
REQ-021 Simultaneous wr_en and rd_en while empty: only the write is accepted; there is no write-to-read bypass.
REQ-022 full and empty are combinational decodes of count (count==DEPTH, count==0) and are valid in the cycle after the edge that changed count.

Reset
REQ-023 While rst_n is high at a rising edge: pointers = 0, count = 0, data_out = 0, empty = 1, full = 0, and wr_en/rd_en are ignored.
REQ-024 Reset applied mid-operation discards all stored data; storage contents need not be cleared.

Configuration
REQ-025 Macro MODPORT_FIFO_ERR_EN defined: add output ports overflow (1 bit) and underflow (1 bit), both registered and reset to 0.
REQ-026 With MODPORT_FIFO_ERR_EN, overflow pulses high for one cycle after an edge with wr_en && full && !rd_en.
REQ-027 With MODPORT_FIFO_ERR_EN, underflow pulses high for one cycle after an edge with rd_en && empty.
REQ-028 Without MODPORT_FIFO_ERR_EN, the overflow and underflow ports and their logic are absent; all other behaviour is identical.

Structure
REQ-029 Package modport_fifo_pkg holds the DATA_WIDTH/DEPTH default constants and a pointer-width function (clog2 of DEPTH).
REQ-030 Sub-module modport_fifo_mem holds the DEPTH x DATA_WIDTH storage array: one synchronous write port and one synchronous read port.
REQ-031 Control logic (pointers, count, flags) stays in modport_fifo.

Verification
REQ-032 Reset, then idle -> empty=1, full=0, data_out=0.
REQ-033 Write 0x11..0x18 (8 writes) -> full=1 after the 8th; a 9th write of 0xFF is dropped; then 8 reads -> data_out sequence 0x11..0x18, empty=1.
REQ-034 Read while empty -> data_out unchanged and empty stays 1; with MODPORT_FIFO_ERR_EN, underflow pulses once.
REQ-035 Fill with 4 entries, then 10 cycles of wr_en=rd_en=1 with incrementing data -> count stays 4, output order preserved, pointers wrap correctly.
REQ-036 Full FIFO with wr_en=rd_en=1 -> oldest entry read, new data not stored, full deasserts.
REQ-037 Reset asserted with 5 entries stored -> next cycle empty=1, data_out=0; a following read returns nothing new.
